gate_power_model: RTL
=====================

GATE_POWER_MODEL -- requirements
Module: gate_power_model

Interface
REQ-001 Parameter N_IN, default 2: number of gate inputs, legal range 2..8.
REQ-002 Parameter DELAY, default 6: propagation delay in clock cycles, legal range 1..16.
REQ-003 Parameter CNT_W, default 16: toggle counter width.
REQ-004 Parameter E_W, default 32: energy accumulator width.
REQ-005 Parameter VOLT, default 10: supply voltage in volts (integer).
REQ-006 Parameter CAP_PF, default 50: load capacitance in pF (integer); E_TOG = VOLT*VOLT*CAP_PF pJ per output toggle (default 5000).
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 reset  input  1  synchronous active-high reset.
REQ-010 in_data  input  N_IN  gate inputs, sampled on each enabled edge.
REQ-011 mode  input  3  gate function: 0 NOR, 1 NAND, 2 OR, 3 AND, 4 XOR, 5 XNOR; 6 and 7 behave as NOR.
REQ-012 enable  input  1  advances the delay pipeline when 1.
REQ-013 clear  input  1  synchronous clear of the statistics only.
REQ-014 q  output  1  delayed gate output.
REQ-015 valid  output  1  high once q carries a real evaluated sample.
REQ-016 toggle_cnt  output  CNT_W  count of counted q transitions.
REQ-017 energy  output  E_W  accumulated switching energy in pJ.
REQ-018 cnt_sat  output  1  sticky flag: toggle_cnt or energy has saturated.

Function
REQ-019 Gate value f = mode function applied across all N_IN bits of in_data; mode and in_data are sampled on the same edge.
REQ-020 Delay pipeline of DELAY stages: on each edge with enable=1, f enters stage 1 and every stage shifts; q = stage DELAY.
REQ-021 Latency: an f sampled at enabled edge k appears on q after the DELAY-th enabled edge counted from edge k.
REQ-022 enable=0: pipeline, q, and fill counter hold; no toggle is counted.
REQ-023 Fill counter increments on enabled edges and saturates at DELAY; valid=1 when fill = DELAY.
REQ-024 Toggle event: an enabled edge where new q != old q and valid was already 1 before that edge; the edge on which valid rises never counts.
REQ-025 On a toggle event, toggle_cnt += 1 saturating at 2^CNT_W-1, and energy += E_TOG saturating at 2^E_W-1.
REQ-026 Each accumulator saturates independently; cnt_sat is set on the first edge at which either accumulator would exceed its maximum, and stays set.
REQ-027 A mode change does not flush the pipeline; in-flight samples keep the mode they were evaluated with.
REQ-028 clear=1: toggle_cnt, energy and cnt_sat are 0 after the edge; pipeline, q and valid are unaffected.
REQ-029 clear and a toggle event on the same edge: clear wins, and the toggle is dropped (toggle_cnt=0).

Reset
REQ-030 reset=1 at an edge: all pipeline stages=0, q=0, fill=0, valid=0, toggle_cnt=0, energy=0, cnt_sat=0.
REQ-031 reset has priority over enable and clear.
REQ-032 reset in mid-operation discards in-flight samples, and refill restarts per REQ-023.

Verification
REQ-033 Defaults, mode=0, in_data=00, enable=1 after reset -> q=1 and valid=1 at the 6th edge; toggle_cnt=0, energy=0.
REQ-034 Continuing from REQ-033, in_data=01 for 1 edge then 00 -> q=0 for exactly 1 cycle, 6 edges later; toggle_cnt=2, energy=10000.
REQ-035 enable low for 3 cycles mid-flight -> q transition is delayed by exactly 3 cycles, and counts are unchanged in the gap.
REQ-036 CNT_W=4, 20 toggle events -> toggle_cnt=15, cnt_sat=1, energy=100000; then clear=1 -> all three are 0 while q is undisturbed.
REQ-037 N_IN=3, mode=4, in_data=111 -> q=1 after DELAY edges; switching to mode=3 mid-pipeline changes q only for samples taken after the switch.
REQ-038 reset asserted 3 edges into the fill, with clear=1 and a pending toggle -> all outputs are 0 next cycle, and valid rises again only after 6 further enabled edges.

Source files
------------

// File: rtl/gate_power_model.sv
// Gate power model: a configurable N_IN-input logic gate whose output passes
// through a DELAY-stage enable-gated pipeline. Output transitions seen after
// the pipeline has filled are counted and charged a fixed switching energy.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset (highest priority)
//   in_data    - gate inputs, sampled on enabled edges
//   mode       - gate function: 0 NOR, 1 NAND, 2 OR, 3 AND, 4 XOR, 5 XNOR, 6/7 NOR
//   enable     - advances the delay pipeline
//   clear      - synchronous clear of toggle_cnt, energy and cnt_sat
//   q          - delayed gate output
//   valid      - q carries a real evaluated sample
//   toggle_cnt - saturating count of counted q transitions
//   energy     - saturating accumulated switching energy (pJ)
//   cnt_sat    - sticky: an accumulator has saturated
module gate_power_model #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned DELAY  = 6,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned E_W    = 32,
  parameter int unsigned VOLT   = 10,
  parameter int unsigned CAP_PF = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_data,
  input  logic [2:0]       mode,
  input  logic             enable,
  input  logic             clear,
  output logic             q,
  output logic             valid,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [E_W-1:0]   energy,
  output logic             cnt_sat
);

  localparam int unsigned FILL_W = $clog2(DELAY + 1);
  localparam int unsigned E_TOG  = VOLT * VOLT * CAP_PF;
  localparam logic [E_W:0]       E_TOG_X = (E_W + 1)'(E_TOG);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(DELAY);

  logic [DELAY-1:0]  pipe_q, pipe_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [E_W-1:0]    energy_q, energy_d;
  logic              sat_q, sat_d;

  logic              f;
  logic [DELAY:0]    shifted;
  logic [E_W:0]      energy_sum;
  logic              toggle;

  // Gate function evaluated on the current inputs
  always_comb begin
    f = 1'b0;
    case (mode)
      3'd1:    f = ~(&in_data);
      3'd2:    f = |in_data;
      3'd3:    f = &in_data;
      3'd4:    f = ^in_data;
      3'd5:    f = ~(^in_data);
      default: f = ~(|in_data);
    endcase
  end

  // Next-state: pipeline shift, fill tracking and statistics update
  always_comb begin
    pipe_d     = pipe_q;
    fill_d     = fill_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    energy_d   = energy_q;
    sat_d      = sat_q;
    toggle     = 1'b0;
    // Extra top bit is the sample falling off the end; it is discarded.
    shifted    = {pipe_q, f};
    energy_sum = {1'b0, energy_q} + E_TOG_X;

    if (enable) begin
      pipe_d = shifted[DELAY-1:0];
      if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
      valid_d = (fill_d == FILL_FULL);
      // Only transitions between two real samples count, so the edge on
      // which valid rises is excluded by using the pre-edge valid.
      toggle = valid_q && (shifted[DELAY-1] != pipe_q[DELAY-1]);
    end

    if (clear) begin
      cnt_d    = '0;
      energy_d = '0;
      sat_d    = 1'b0;
    end else if (toggle) begin
      if (cnt_q == CNT_MAX) sat_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
      // Carry out of the widened sum means the add would exceed the maximum.
      if (energy_sum[E_W]) begin
        energy_d = '1;
        sat_d    = 1'b1;
      end else begin
        energy_d = energy_sum[E_W-1:0];
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q   <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      energy_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      pipe_q   <= pipe_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      energy_q <= energy_d;
      sat_q    <= sat_d;
    end
  end

  assign q          = pipe_q[DELAY-1];
  assign valid      = valid_q;
  assign toggle_cnt = cnt_q;
  assign energy     = energy_q;
  assign cnt_sat    = sat_q;

endmodule
